// File: rtl/mips_trace_collector_if.sv
// Event capture inputs and record stream between the CPU-side bench and the trace collector.
interface mips_trace_collector_if #(
  parameter int unsigned STAMP_W = 16
);
  logic               grf_we;
  logic [31:0]        grf_pc;
  logic [4:0]         grf_addr;
  logic [31:0]        grf_wdata;
  logic               dm_we;
  logic [31:0]        dm_pc;
  logic [31:0]        dm_addr;
  logic [31:0]        dm_wdata;
  logic               out_valid;
  logic               out_ready;
  logic               out_kind;
  logic [31:0]        out_pc;
  logic [31:0]        out_addr;
  logic [31:0]        out_data;
  logic [STAMP_W-1:0] out_stamp;

  // Event source and record reader
  modport master (
    output grf_we, grf_pc, grf_addr, grf_wdata,
    output dm_we, dm_pc, dm_addr, dm_wdata,
    output out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data, out_stamp
  );

  // Collector
  modport slave (
    input  grf_we, grf_pc, grf_addr, grf_wdata,
    input  dm_we, dm_pc, dm_addr, dm_wdata,
    input  out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data, out_stamp
  );
endinterface

// File: rtl/mips_trace_collector.sv
// Captures GRF/DM write events, stamps them with the run cycle, buffers them in a
// show-ahead FIFO and drains them over a valid/ready stream; done once the run window
// has closed and every record has been consumed.
module mips_trace_collector #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 2048,
  parameter int unsigned STAMP_W    = 16,
  parameter bit          DROP_ZERO  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_trace_collector_if.slave  bus,
  output logic                   capturing,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned FW = PW + 1;

  typedef struct packed {
    logic               kind;
    logic [31:0]        pc;
    logic [31:0]        addr;
    logic [31:0]        data;
    logic [STAMP_W-1:0] stamp;
  } rec_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state;
  logic [STAMP_W-1:0] cyc;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  rec_t               mem [DEPTH];
  rec_t               head;
  logic               head_valid;

  logic          pop;
  logic          grf_q;
  logic          dm_q;
  logic          grf_ok;
  logic          dm_ok;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [PW-1:0] occ;
  logic [PW-1:0] remain;
  logic [FW-1:0] free;
  logic [AW-1:0] w0_idx;
  logic [AW-1:0] w1_idx;
  logic [AW-1:0] rn_idx;
  logic [8:0]    drop_sum;
  rec_t          grf_rec;
  rec_t          dm_rec;
  rec_t          first_rec;

  // Event qualification, free-slot accounting and drop priority (DM dropped before GRF)
  always_comb begin
    pop       = head_valid && bus.out_ready;
    grf_q     = (state == S_RUN) && bus.grf_we && !(DROP_ZERO && (bus.grf_addr == 5'd0));
    dm_q      = (state == S_RUN) && bus.dm_we;
    occ       = wr_ptr - rd_ptr;
    remain    = occ - PW'(pop);
    free      = FW'(DEPTH) - FW'(occ) + FW'(pop);
    grf_ok    = grf_q && (free != FW'(0));
    dm_ok     = dm_q && (grf_q ? (free >= FW'(2)) : (free != FW'(0)));
    n_push    = 2'(grf_ok) + 2'(dm_ok);
    n_drop    = 2'(grf_q && !grf_ok) + 2'(dm_q && !dm_ok);
    drop_sum  = 9'(drop_cnt) + 9'(n_drop);
    w0_idx    = wr_ptr[AW-1:0];
    w1_idx    = w0_idx + AW'(1);
    rn_idx    = rd_ptr[AW-1:0] + AW'(pop);
    grf_rec   = '{kind: 1'b0, pc: bus.grf_pc, addr: 32'(bus.grf_addr),
                  data: bus.grf_wdata, stamp: cyc};
    dm_rec    = '{kind: 1'b1, pc: bus.dm_pc, addr: bus.dm_addr,
                  data: bus.dm_wdata, stamp: cyc};
    first_rec = grf_ok ? grf_rec : dm_rec;
  end

  // FIFO storage; the GRF record takes the lower slot when both are pushed
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[w0_idx] <= first_rec;
    if (n_push == 2'd2) mem[w1_idx] <= dm_rec;
  end

  // Run-window FSM, pointers, show-ahead head register and drop bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RUN;
      cyc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head       <= '0;
      head_valid <= 1'b0;
      capturing  <= 1'b1;
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
      done       <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(n_push);

      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end

      // Next head comes from storage if anything survives the pop, else from this edge's push
      if (remain != PW'(0)) begin
        head       <= mem[rn_idx];
        head_valid <= 1'b1;
      end else if (n_push != 2'd0) begin
        head       <= first_rec;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end

      case (state)
        S_RUN: begin
          if (cyc == STAMP_W'(MAX_CYCLES - 1)) begin
            state     <= S_DRAIN;
            capturing <= 1'b0;
          end else begin
            cyc <= cyc + STAMP_W'(1);
          end
        end
        S_DRAIN: begin
          if (occ == PW'(0)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.out_kind  = head.kind;
  assign bus.out_pc    = head.pc;
  assign bus.out_addr  = head.addr;
  assign bus.out_data  = head.data;
  assign bus.out_stamp = head.stamp;

endmodule

// File: tb/tb_mips_trace_collector.sv
// Directed bench for mips_trace_collector: a default instance (DEPTH 16, long window) and a
// small instance (DEPTH 4, MAX_CYCLES 8) for drop priority and run-window close.
module tb_mips_trace_collector;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic       cap_a, ovf_a, done_a;
  logic [7:0] drop_a;
  logic       cap_b, ovf_b, done_b;
  logic [7:0] drop_b;
  int         vectors;
  int         miscompares;
  int         cyc;

  mips_trace_collector_if #(.STAMP_W(16)) ifa ();
  mips_trace_collector_if #(.STAMP_W(16)) ifb ();

  mips_trace_collector #(
    .DEPTH(16), .MAX_CYCLES(2048), .STAMP_W(16), .DROP_ZERO(1'b1)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa),
    .capturing(cap_a), .overflow(ovf_a), .drop_cnt(drop_a), .done(done_a)
  );

  mips_trace_collector #(
    .DEPTH(4), .MAX_CYCLES(8), .STAMP_W(16), .DROP_ZERO(1'b1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb),
    .capturing(cap_b), .overflow(ovf_b), .drop_cnt(drop_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_a();
    ifa.grf_we = 1'b0; ifa.grf_pc = '0; ifa.grf_addr = '0; ifa.grf_wdata = '0;
    ifa.dm_we  = 1'b0; ifa.dm_pc  = '0; ifa.dm_addr  = '0; ifa.dm_wdata  = '0;
  endtask

  task automatic clr_b();
    ifb.grf_we = 1'b0; ifb.grf_pc = '0; ifb.grf_addr = '0; ifb.grf_wdata = '0;
    ifb.dm_we  = 1'b0; ifb.dm_pc  = '0; ifb.dm_addr  = '0; ifb.dm_wdata  = '0;
  endtask

  task automatic grf_a(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
    ifa.grf_we = 1'b1; ifa.grf_pc = pc; ifa.grf_addr = addr; ifa.grf_wdata = data;
  endtask

  task automatic grf_b(input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
    ifb.grf_we = 1'b1; ifb.grf_pc = pc; ifb.grf_addr = addr; ifb.grf_wdata = data;
  endtask

  task automatic dm_b(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
    ifb.dm_we = 1'b1; ifb.dm_pc = pc; ifb.dm_addr = addr; ifb.dm_wdata = data;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    clr_a();
    clr_b();
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_capturing", cap_a, 1);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_drop_cnt", drop_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pc", ifa.out_pc, 0);
    chk("rst_stamp", ifa.out_stamp, 0);
    chk("rst_data", ifa.out_data, 0);

    // Single GRF event with reader always ready
    rst_a = 1'b0;
    cyc = 0;
    ifa.out_ready = 1'b1;
    tick(); tick(); tick();
    grf_a(32'h3000, 5'd8, 32'h1234);
    tick();
    clr_a();
    chk("grf1_valid", ifa.out_valid, 1);
    chk("grf1_kind", ifa.out_kind, 0);
    chk("grf1_pc", ifa.out_pc, 32'h3000);
    chk("grf1_addr", ifa.out_addr, 32'd8);
    chk("grf1_data", ifa.out_data, 32'h1234);
    chk("grf1_stamp", ifa.out_stamp, 3);
    tick();
    chk("grf1_gone", ifa.out_valid, 0);
    chk("grf1_keep", ifa.out_data, 32'h1234);

    // GRF and DM in the same cycle, reader stalled for four cycles
    tick(); tick();
    ifa.out_ready = 1'b0;
    grf_a(32'h3004, 5'd9, 32'hAA);
    ifa.dm_we = 1'b1; ifa.dm_pc = 32'h3008; ifa.dm_addr = 32'h10; ifa.dm_wdata = 32'hBB;
    tick();
    clr_a();
    for (int k = 0; k < 4; k++) begin
      chk("pair_stall_valid", ifa.out_valid, 1);
      chk("pair_stall_kind", ifa.out_kind, 0);
      chk("pair_stall_addr", ifa.out_addr, 32'd9);
      chk("pair_stall_data", ifa.out_data, 32'hAA);
      chk("pair_stall_stamp", ifa.out_stamp, 7);
      if (k == 3) ifa.out_ready = 1'b1;
      tick();
    end
    chk("pair_dm_valid", ifa.out_valid, 1);
    chk("pair_dm_kind", ifa.out_kind, 1);
    chk("pair_dm_pc", ifa.out_pc, 32'h3008);
    chk("pair_dm_addr", ifa.out_addr, 32'h10);
    chk("pair_dm_data", ifa.out_data, 32'hBB);
    chk("pair_dm_stamp", ifa.out_stamp, 7);
    tick();
    chk("pair_empty", ifa.out_valid, 0);
    chk("pair_keep_kind", ifa.out_kind, 1);

    // Writes to $0 are filtered, not counted
    grf_a(32'h3010, 5'd0, 32'hDEAD);
    tick();
    clr_a();
    tick();
    chk("zero_valid", ifa.out_valid, 0);
    chk("zero_drop", drop_a, 0);
    chk("zero_ovf", ovf_a, 0);

    // 17 events into a 16-deep FIFO with reader stalled
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      grf_a(32'h4000 + 32'(4 * i), 5'(i + 1), 32'h100 + 32'(i));
      tick();
    end
    clr_a();
    chk("ovf_flag", ovf_a, 1);
    chk("ovf_drop", drop_a, 1);
    chk("ovf_valid", ifa.out_valid, 1);
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_valid", ifa.out_valid, 1);
      chk("ovf_drain_data", ifa.out_data, 32'h100 + 32'(i));
      chk("ovf_drain_pc", ifa.out_pc, 32'h4000 + 32'(4 * i));
      tick();
    end
    chk("ovf_drained", ifa.out_valid, 0);
    chk("ovf_drop_hold", drop_a, 1);

    // Asynchronous reset with records queued
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      grf_a(32'h5000, 5'(10 + i), 32'h500 + 32'(i));
      tick();
    end
    clr_a();
    chk("mid_queued", ifa.out_valid, 1);
    #4;
    rst_a = 1'b1;
    #1;
    chk("mid_rst_valid", ifa.out_valid, 0);
    chk("mid_rst_ovf", ovf_a, 0);
    chk("mid_rst_drop", drop_a, 0);
    chk("mid_rst_data", ifa.out_data, 0);
    chk("mid_rst_cap", cap_a, 1);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    cyc = 0;
    tick(); tick();
    grf_a(32'h5004, 5'd3, 32'h600);
    tick();
    clr_a();
    chk("post_rst_valid", ifa.out_valid, 1);
    chk("post_rst_stamp", ifa.out_stamp, 2);
    chk("post_rst_data", ifa.out_data, 32'h600);

    // Small instance: DM dropped ahead of GRF, then run window closes at cycle 8
    tick();
    rst_b = 1'b0;
    cyc = 0;
    tick();
    grf_b(32'h6000, 5'd1, 32'hA1);
    dm_b(32'h6004, 32'h100, 32'hD1);
    tick();
    clr_b();
    grf_b(32'h6008, 5'd2, 32'hA2);
    tick();
    grf_b(32'h600C, 5'd3, 32'hA3);
    dm_b(32'h6010, 32'h104, 32'hD3);
    tick();
    clr_b();
    chk("b_prio_drop", drop_b, 1);
    chk("b_prio_ovf", ovf_b, 1);
    chk("b_head_valid", ifb.out_valid, 1);
    chk("b_head_kind", ifb.out_kind, 0);
    chk("b_head_data", ifb.out_data, 32'hA1);
    chk("b_head_stamp", ifb.out_stamp, 1);
    ifb.out_ready = 1'b1;
    tick();
    chk("b_r2_kind", ifb.out_kind, 1);
    chk("b_r2_addr", ifb.out_addr, 32'h100);
    chk("b_r2_data", ifb.out_data, 32'hD1);
    chk("b_r2_stamp", ifb.out_stamp, 1);
    tick();
    chk("b_r3_data", ifb.out_data, 32'hA2);
    chk("b_r3_stamp", ifb.out_stamp, 2);
    tick();
    chk("b_r4_kind", ifb.out_kind, 0);
    chk("b_r4_data", ifb.out_data, 32'hA3);
    chk("b_r4_stamp", ifb.out_stamp, 3);
    chk("b_cap_c7", cap_b, 1);
    grf_b(32'h7000, 5'd5, 32'h77);
    tick();
    clr_b();
    chk("b_cap_c8", cap_b, 0);
    chk("b_last_valid", ifb.out_valid, 1);
    chk("b_last_data", ifb.out_data, 32'h77);
    chk("b_last_stamp", ifb.out_stamp, 7);
    chk("b_done_c8", done_b, 0);
    grf_b(32'h7004, 5'd6, 32'h88);
    tick();
    clr_b();
    chk("b_c9_valid", ifb.out_valid, 0);
    chk("b_c9_done", done_b, 0);
    tick();
    chk("b_c10_done", done_b, 1);
    chk("b_c10_valid", ifb.out_valid, 0);
    chk("b_c10_keep", ifb.out_data, 32'h77);
    chk("b_c10_drop", drop_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_trace_collector.md
Name: mips_trace_collector

Overview:
- Sink-side companion to the single-cycle MIPS CPU under test. The bench drives the clock and reset; this block is the other end of that run.
- It captures architectural write events (GRF writes, DM writes) from the CPU, tags each with the PC and a cycle stamp, and buffers them in a FIFO.
- It drains the records over a valid/ready stream to the judger-side reader.
- It enforces the run window (MAX_CYCLES) and raises done once every captured record has been consumed.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- MAX_CYCLES, 2048, capture window length in cycles after reset release.
- STAMP_W, 16, cycle-stamp width; must hold MAX_CYCLES.
- DROP_ZERO, 1, when 1, GRF writes to register 0 are not recorded.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- grf_we  in  1  GRF write enable this cycle
- grf_pc  in  32  PC of the instruction writing the GRF
- grf_addr  in  5  destination register
- grf_wdata  in  32  value written to the GRF
- dm_we  in  1  DM write enable this cycle
- dm_pc  in  32  PC of the store instruction
- dm_addr  in  32  byte address written
- dm_wdata  in  32  value written to DM
- out_valid  out  1  record available
- out_ready  in  1  reader accepts record
- out_kind  out  1  0 = GRF record, 1 = DM record
- out_pc  out  32  record PC
- out_addr  out  32  GRF index zero-extended, or DM address
- out_data  out  32  written value
- out_stamp  out  STAMP_W  cycle in which the write occurred
- capturing  out  1  high in the RUN state
- overflow  out  1  sticky; at least one event was dropped
- drop_cnt  out  8  dropped-event count, saturating at 255
- done  out  1  run complete and FIFO empty

Behaviour:
- Reset (async, any time, including mid-run or mid-handshake):
  - FIFO is emptied; pointers and cycle counter are cleared.
  - State goes to RUN.
  - out_valid=0, out_kind/out_pc/out_addr/out_data/out_stamp=0, capturing=1, overflow=0, drop_cnt=0, done=0.
- Cycle counter:
  - 0 in the first clock cycle after reset deasserts.
  - Increments by 1 per cycle while in RUN, and freezes on leaving RUN.
- States:
  - RUN: events are captured. Move to DRAIN on the edge ending the cycle in which the counter equals MAX_CYCLES-1; that cycle's events are still captured.
  - DRAIN: capturing=0 and all inputs are ignored. Move to DONE on the first edge at which the FIFO is empty with no push pending.
  - DONE: done=1 and out_valid=0. Held until reset.
- Event qualification:
  - An event is sampled on a rising edge with grf_we or dm_we high.
  - When DROP_ZERO=1, a GRF event with grf_addr==0 is discarded. It is not counted as dropped.
- Push rules:
  - Each qualified event pushes one record with stamp = current cycle counter.
  - If both events fire in the same cycle, both are pushed: the GRF record first, then the DM record. This needs two free slots.
  - Free slots = DEPTH - occupancy + (1 if a pop occurs on this edge). Full-with-simultaneous-pop therefore accepts one push.
  - If space is insufficient, events are dropped in priority order: the DM record is dropped first, then the GRF record.
  - Each dropped record sets overflow and increments drop_cnt (saturating).
- Output stream:
  - Show-ahead FIFO: a record pushed at edge t appears on out_* with out_valid=1 right after edge t, so it is sampleable in cycle t+1.
  - Pop occurs on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - When the FIFO is empty, out_valid=0 and out_* keep their last values.
  - Records emerge in push order.
  - Pointers wrap modulo DEPTH; the full and empty cases are distinguished by an extra pointer bit.
- Encoding: out_addr = {27'b0, grf_addr} for GRF records.

Test Plan:
- GRF event, ready=1: reset 5 cycles, then grf_we=1, pc=0x3000, addr=8, wdata=0x1234 at cycle 3 -> the next cycle shows out_valid=1, kind=0, pc=0x3000, addr=8, data=0x1234, stamp=3, held for exactly one cycle.
- Same-cycle GRF and DM events: grf (addr=9, 0xAA) plus dm (addr=0x10, 0xBB) in cycle 7, out_ready=0 for 4 cycles -> two records, GRF then DM, both stamp=7, fields stable while stalled.
- Overflow: out_ready=0, 17 GRF events, DEPTH=16 -> 16 records stored, overflow=1, drop_cnt=1. Then ready=1 -> exactly 16 records drained, in order.
- $0 filtering: grf_addr=0 event with DROP_ZERO=1 -> no record, drop_cnt stays 0.
- Run window: MAX_CYCLES=8, events at cycles 7 and 8 -> only the cycle-7 record is stored. capturing falls after cycle 7. done=1 one edge after that record is popped.
- Mid-run reset: 3 records queued, reset pulse asserted between edges -> out_valid=0, overflow=0 immediately (asynchronously). After release, the first event is stamped with its cycle counted from 0.
